// File: rtl/master_driver_bfm.sv
// Serial master driver: turns one request word into a chip-selected, mode-0 style
// frame on sclk/mosi/miso. Define MASTER_DRIVER_BFM_LSB_FIRST_EN for LSB-first shifting.
`timescale 1ns/1ps
module master_driver_bfm #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  busy,
    output logic                  cs_n,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

    state_e                state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  sclk_q, sclk_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

    logic [DATA_WIDTH-1:0] tx_advanced;
    logic [DATA_WIDTH-1:0] rx_captured;
    logic                  tx_bit;
    logic                  div_done;

`ifdef MASTER_DRIVER_BFM_LSB_FIRST_EN
    assign tx_bit      = tx_q[0];
    assign tx_advanced = {1'b0, tx_q[DATA_WIDTH-1:1]};
    assign rx_captured = {miso, rx_q[DATA_WIDTH-1:1]};
`else
    assign tx_bit      = tx_q[DATA_WIDTH-1];
    assign tx_advanced = {tx_q[DATA_WIDTH-2:0], 1'b0};
    assign rx_captured = {rx_q[DATA_WIDTH-2:0], miso};
`endif

    assign div_done = (div_cnt_q == DIV_LAST);

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        sclk_d       = sclk_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;

        unique case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                sclk_d    = 1'b0;
                if (req_valid && req_ready) begin
                    state_d = SETUP;
                    tx_d    = req_data;
                    rx_d    = '0;
                end
            end
            SETUP: begin
                if (div_done) begin
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_done) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = rx_captured;
                    end else if (bit_cnt_q == BIT_LAST) begin
                        // Last falling edge: mosi keeps its final bit until cs_n rises.
                        state_d = HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = tx_advanced;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_done) begin
                    div_cnt_d    = '0;
                    state_d      = IDLE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = rx_q;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            sclk_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            sclk_q       <= sclk_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign cs_n       = (state_q == IDLE);
    assign busy       = ~cs_n;
    assign req_ready  = cs_n & ~preset;
    assign sclk       = sclk_q;
    assign mosi       = ~cs_n & tx_bit;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_master_driver_bfm.sv
// Self-checking bench for master_driver_bfm: vector table plus directed corner sequences,
// with a slave model on miso and a scoreboard of expected response words.
`timescale 1ns/1ps
module tb_master_driver_bfm;

    localparam int DW = 8;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          req_valid = 1'b0;
    logic [DW-1:0] req_data = '0;
    logic          req_ready, resp_valid, busy, cs_n, sclk, mosi, miso;
    logic [DW-1:0] resp_data;

    logic          req_valid16 = 1'b0;
    logic [15:0]   req_data16 = '0;
    logic          req_ready16, resp_valid16, busy16, cs_n16, sclk16, mosi16;
    logic [15:0]   resp_data16;

    always #5 pclk = ~pclk;

    master_driver_bfm #(.DATA_WIDTH(DW), .CLK_DIV(2)) u_dut (
        .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
        .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    master_driver_bfm #(.DATA_WIDTH(16), .CLK_DIV(1)) u_dut16 (
        .pclk(pclk), .preset(preset), .req_valid(req_valid16), .req_ready(req_ready16),
        .req_data(req_data16), .resp_valid(resp_valid16), .resp_data(resp_data16), .busy(busy16),
        .cs_n(cs_n16), .sclk(sclk16), .mosi(mosi16), .miso(1'b1)
    );

    typedef struct {
        logic [DW-1:0] req;
        logic [DW-1:0] slave;
        logic [DW-1:0] exp_resp;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] slave_q[$];
    logic [DW-1:0] exp_q[$];
    logic          mosi_q[$];
    int            len_q[$];
    int            gap_q[$];
    int            resp_times[$];
    logic [DW-1:0] cur_slave = '0;
    int            cyc = 0;
    int            cs_low = 0;
    int            cs_high = 0;
    int            rise_cnt = 0;
    logic          sclk_prev = 1'b0;

    // Slave model: presents the next bit before each rising sclk.
`ifdef MASTER_DRIVER_BFM_LSB_FIRST_EN
    assign miso = (rise_cnt < DW) ? cur_slave[3'(rise_cnt)] : 1'b0;
`else
    assign miso = (rise_cnt < DW) ? cur_slave[3'(DW - 1 - rise_cnt)] : 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge pclk) begin
        cyc++;
        if (busy) check("ready_while_busy", 32'(req_ready), 32'd0);
        if (cs_n) check("mosi_idle", 32'(mosi), 32'd0);
        if (!cs_n) begin
            if (cs_low == 0) begin
                gap_q.push_back(cs_high);
                if (slave_q.size() > 0) cur_slave = slave_q.pop_front();
            end
            cs_low++;
            cs_high = 0;
            if (sclk && !sclk_prev) begin
                mosi_q.push_back(mosi);
                rise_cnt++;
            end
        end else begin
            if (cs_low != 0) len_q.push_back(cs_low);
            cs_low = 0;
            cs_high++;
            rise_cnt = 0;
        end
        sclk_prev = sclk;
        if (resp_valid) begin
            resp_times.push_back(cyc);
            if (exp_q.size() == 0) check("resp_without_request", 32'(exp_q.size()), 32'd1);
            else check("resp_data", 32'(resp_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] s, input logic [DW-1:0] e);
        int n = 0;
        slave_q.push_back(s);
        req_data  = d;
        req_valid = 1'b1;
        while (!req_ready && n < 300) begin
            @(negedge pclk);
            n++;
        end
        check("accept_timeout", 32'(n < 300), 32'd1);
        exp_q.push_back(e);
        @(negedge pclk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge pclk);
            n++;
        end
        check("done_timeout", 32'(n < 500), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge pclk);
    endtask

    task automatic check_mosi(input logic [DW-1:0] d, input int frame);
        logic exp_bit;
        check("mosi_count", 32'(mosi_q.size() >= (frame + 1) * DW), 32'd1);
        for (int i = 0; i < DW; i++) begin
`ifdef MASTER_DRIVER_BFM_LSB_FIRST_EN
            exp_bit = d[i];
`else
            exp_bit = d[DW - 1 - i];
`endif
            if (frame * DW + i < mosi_q.size())
                check($sformatf("mosi_bit%0d_f%0d", i, frame), 32'(mosi_q[frame * DW + i]), 32'(exp_bit));
        end
    endtask

    task automatic clear_logs();
        mosi_q.delete();
        len_q.delete();
        gap_q.delete();
        resp_times.delete();
    endtask

    initial begin
        vec_t vecs[5];
        int   n, rises;
        logic prev;

        vecs[0] = '{req: 8'hA5, slave: 8'h3C, exp_resp: 8'h3C};
        vecs[1] = '{req: 8'h00, slave: 8'hFF, exp_resp: 8'hFF};
        vecs[2] = '{req: 8'hFF, slave: 8'h00, exp_resp: 8'h00};
        vecs[3] = '{req: 8'h5A, slave: 8'h81, exp_resp: 8'h81};
        vecs[4] = '{req: 8'h01, slave: 8'h80, exp_resp: 8'h80};

        // Reset state
        repeat (3) @(negedge pclk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_ready_in_reset", 32'(req_ready), 32'd0);
        preset = 1'b0;
        #1;
        check("rst_ready_after", 32'(req_ready), 32'd1);
        @(negedge pclk);

        // Table-driven single frames
        for (int i = 0; i < 5; i++) begin
            clear_logs();
            send(vecs[i].req, vecs[i].slave, vecs[i].exp_resp);
            wait_done();
            check($sformatf("len_count_v%0d", i), 32'(len_q.size()), 32'd1);
            if (len_q.size() > 0) check($sformatf("cs_low_len_v%0d", i), 32'(len_q[0]), 32'd36);
            check($sformatf("resp_pulses_v%0d", i), 32'(resp_times.size()), 32'd1);
            check_mosi(vecs[i].req, 0);
            repeat (5) @(negedge pclk);
            check($sformatf("resp_hold_v%0d", i), 32'(resp_data), 32'(vecs[i].exp_resp));
        end

        // Back-to-back requests
        clear_logs();
        send(8'h01, 8'hC3, 8'hC3);
        send(8'hFF, 8'h96, 8'h96);
        wait_done();
        check("b2b_frames", 32'(len_q.size()), 32'd2);
        if (len_q.size() == 2) begin
            check("b2b_len0", 32'(len_q[0]), 32'd36);
            check("b2b_len1", 32'(len_q[1]), 32'd36);
        end
        if (gap_q.size() > 0) check("b2b_gap", 32'(gap_q[gap_q.size() - 1]), 32'd1);
        check("b2b_resp_count", 32'(resp_times.size()), 32'd2);
        if (resp_times.size() == 2) check("b2b_resp_spacing", 32'(resp_times[1] - resp_times[0]), 32'd37);
        check_mosi(8'h01, 0);
        check_mosi(8'hFF, 1);

        // Request pulsed during SHIFT is ignored
        clear_logs();
        send(8'h33, 8'h44, 8'h44);
        n = 0;
        while (!sclk && n < 100) begin
            @(negedge pclk);
            n++;
        end
        check("pulse_sclk_timeout", 32'(n < 100), 32'd1);
        req_data  = 8'hEE;
        req_valid = 1'b1;
        #1;
        check("pulse_ready", 32'(req_ready), 32'd0);
        @(negedge pclk);
        req_valid = 1'b0;
        wait_done();
        repeat (40) @(negedge pclk);
        check("pulse_resp_count", 32'(resp_times.size()), 32'd1);
        check("pulse_frames", 32'(len_q.size()), 32'd1);
        check("pulse_busy", 32'(busy), 32'd0);

        // Reset at the 4th rising sclk aborts the frame
        clear_logs();
        send(8'hA5, 8'h3C, 8'h3C);
        n = 0;
        rises = 0;
        prev = sclk;
        while (rises < 4 && n < 200) begin
            @(negedge pclk);
            if (sclk && !prev) rises++;
            prev = sclk;
            n++;
        end
        check("abort_rise_timeout", 32'(n < 200), 32'd1);
        preset = 1'b1;
        @(negedge pclk);
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mosi", 32'(mosi), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        check("abort_resp_data", 32'(resp_data), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        slave_q.delete();
        preset = 1'b0;
        #1;
        check("abort_ready_after", 32'(req_ready), 32'd1);
        repeat (40) @(negedge pclk);
        check("abort_no_resp", 32'(resp_times.size()), 32'd0);
        clear_logs();
        send(8'h5A, 8'h81, 8'h81);
        wait_done();
        check("post_abort_resp_count", 32'(resp_times.size()), 32'd1);
        if (len_q.size() > 0) check("post_abort_len", 32'(len_q[0]), 32'd36);
        check_mosi(8'h5A, 0);

        // 16-bit, CLK_DIV=1 instance with miso tied high
        begin
            int          low16, rises16, last_rise, got16;
            logic [15:0] mosi_val, rdata16;
            logic        prev16;
            req_data16  = 16'h8001;
            req_valid16 = 1'b1;
            n = 0;
            while (!req_ready16 && n < 100) begin
                @(negedge pclk);
                n++;
            end
            check("w16_accept_timeout", 32'(n < 100), 32'd1);
            @(negedge pclk);
            req_valid16 = 1'b0;
            low16 = 0; rises16 = 0; last_rise = -1; got16 = 0;
            mosi_val = '0; rdata16 = '0; prev16 = 1'b0;
            for (int c = 0; c < 80; c++) begin
                if (!cs_n16) low16++;
                if (sclk16 && !prev16) begin
                    if (last_rise >= 0) check("w16_sclk_period", 32'(c - last_rise), 32'd2);
                    last_rise = c;
                    rises16++;
                    mosi_val = {mosi_val[14:0], mosi16};
                end
                prev16 = sclk16;
                if (resp_valid16) begin
                    got16++;
                    rdata16 = resp_data16;
                end
                @(negedge pclk);
            end
            check("w16_cs_low", 32'(low16), 32'd34);
            check("w16_rises", 32'(rises16), 32'd16);
            check("w16_mosi", 32'(mosi_val), 32'h8001);
            check("w16_resp_count", 32'(got16), 32'd1);
            check("w16_resp_data", 32'(rdata16), 32'hFFFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
